exec_muldiv_unit: RTL and testbench

- Execute-stage consumer of the decode→execute pipeline register; implements RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as a multi-cycle iterative unit.
- Drives the `stall` signal back to the decode→execute register so the presented instruction stays held until the result is handed to writeback.
- Results are tagged with `rob_id` for the ROB/writeback path.

---
 rtl/exec_muldiv_unit_pkg.sv | 87 ++++++++
 rtl/exec_muldiv_unit_if.sv | 28 ++
 rtl/exec_muldiv_unit_datapath.sv | 102 ++++++++++
 rtl/exec_muldiv_unit.sv | 134 +++++++++++++
 tb/tb_exec_muldiv_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/exec_muldiv_unit_pkg.sv
// Shared definitions for the RV32M execute unit: widths, decode constants,
// FSM encoding and the arithmetic helpers used by both the iterative
// datapath and the single-cycle fast path.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplier).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package exec_muldiv_unit_pkg;

    localparam int WORD_SIZE = `WORD_SIZE;
    localparam int ROB_ID_SZ = 7;
    localparam int CNT_W     = $clog2(WORD_SIZE);

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef logic [WORD_SIZE-1:0]   word_t;
    typedef logic [2*WORD_SIZE-1:0] dword_t;

    localparam word_t  WORD_ZERO  = {WORD_SIZE{1'b0}};
    localparam word_t  WORD_ONES  = {WORD_SIZE{1'b1}};
    localparam word_t  WORD_ONE   = {{(WORD_SIZE-1){1'b0}}, 1'b1};
    localparam word_t  WORD_MIN   = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam dword_t DWORD_ONE  = {{(2*WORD_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Division ops all have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as two's complement for MULH, MULHSU, DIV, REM.
    function automatic logic s1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV, REM.
    function automatic logic s2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Absolute value when the operand is signed and negative; the most
    // negative value maps onto itself, which is its correct unsigned magnitude.
    function automatic word_t magnitude(input word_t v, input logic sgn);
        return (sgn && v[WORD_SIZE-1]) ? (~v + WORD_ONE) : v;
    endfunction

    // Whether the magnitude result must be negated: remainders follow the
    // dividend sign, products and quotients follow the XOR of both signs.
    function automatic logic result_negative(input logic [2:0] f3, input word_t a, input word_t b);
        logic na;
        logic nb;
        na = s1_signed(f3) && a[WORD_SIZE-1];
        nb = s2_signed(f3) && b[WORD_SIZE-1];
        return (f3[2] && f3[1]) ? na : (na ^ nb);
    endfunction

    // Sign-correct a magnitude product and pick the low or high word.
    function automatic word_t mul_pick(input logic [2:0] f3, input dword_t mag_prod, input logic neg);
        dword_t p;
        p = neg ? (~mag_prod + DWORD_ONE) : mag_prod;
        return (f3 == F3_MUL) ? p[WORD_SIZE-1:0] : p[2*WORD_SIZE-1:WORD_SIZE];
    endfunction

    // Pick remainder (high half) or quotient (low half) and sign-correct it.
    function automatic word_t div_pick(input logic [2:0] f3, input dword_t rem_quo, input logic neg);
        word_t v;
        v = f3[1] ? rem_quo[2*WORD_SIZE-1:WORD_SIZE] : rem_quo[WORD_SIZE-1:0];
        return neg ? (~v + WORD_ONE) : v;
    endfunction

endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Decode->execute and execute->writeback signals of the RV32M unit.
// The master side is the pipeline feeding the unit; the slave side is the unit.
interface exec_muldiv_unit_if
    import exec_muldiv_unit_pkg::*;
;
    logic                 valid;
    logic [6:0]           opcode;
    logic [6:0]           funct7;
    logic [2:0]           funct3;
    word_t                s1;
    word_t                s2;
    logic [ROB_ID_SZ-1:0] rob_id;
    logic                 wb_stall;
    logic                 stall;
    word_t                result;
    logic [ROB_ID_SZ-1:0] rob_id_out;
    logic                 result_valid;

    modport master (
        output valid, opcode, funct7, funct3, s1, s2, rob_id, wb_stall,
        input  stall, result, rob_id_out, result_valid
    );

    modport slave (
        input  valid, opcode, funct7, funct3, s1, s2, rob_id, wb_stall,
        output stall, result, rob_id_out, result_valid
    );
endinterface

// File: rtl/exec_muldiv_unit_datapath.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or one
// restoring-subtract (divide) step per cycle on operand magnitudes, with
// sign fix-up applied to the value produced by the current step.
module muldiv_iter_datapath
    import exec_muldiv_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       step_i,
    input  logic [2:0] funct3_i,
    input  word_t      s1_i,
    input  word_t      s2_i,
    output word_t      final_o
);

    // prod_q: multiply = {partial high, remaining multiplier};
    //         divide   = {partial remainder, dividend/quotient bits}.
    dword_t     prod_q, prod_d;
    word_t      opnd_q, opnd_d;
    logic [2:0] op_q, op_d;
    logic       neg_q, neg_d;

    word_t              mag1_s;
    word_t              mag2_s;
    dword_t             step_s;
    logic [WORD_SIZE:0] add_s;
    logic [WORD_SIZE:0] rem_sh_s;
    logic [WORD_SIZE:0] diff_s;

    // Operand magnitudes of the instruction being loaded.
    always_comb begin
        mag1_s = magnitude(s1_i, s1_signed(funct3_i));
        mag2_s = magnitude(s2_i, s2_signed(funct3_i));
    end

    // One iteration of shift-add or restoring division on the current state.
    always_comb begin
        add_s    = {1'b0, prod_q[2*WORD_SIZE-1:WORD_SIZE]}
                 + (prod_q[0] ? {1'b0, opnd_q} : {(WORD_SIZE+1){1'b0}});
        rem_sh_s = {prod_q[2*WORD_SIZE-1:WORD_SIZE], prod_q[WORD_SIZE-1]};
        diff_s   = rem_sh_s - {1'b0, opnd_q};
        step_s   = prod_q;
        if (is_div(op_q)) begin
            if (diff_s[WORD_SIZE]) begin
                step_s = {rem_sh_s[WORD_SIZE-1:0], prod_q[WORD_SIZE-2:0], 1'b0};
            end else begin
                step_s = {diff_s[WORD_SIZE-1:0], prod_q[WORD_SIZE-2:0], 1'b1};
            end
        end else begin
            step_s = {add_s, prod_q[WORD_SIZE-1:1]};
        end
    end

    // Next-state selection: load a new operation, advance one step, or hold.
    always_comb begin
        prod_d = prod_q;
        opnd_d = opnd_q;
        op_d   = op_q;
        neg_d  = neg_q;
        if (load_i) begin
            op_d  = funct3_i;
            neg_d = result_negative(funct3_i, s1_i, s2_i);
            if (is_div(funct3_i)) begin
                opnd_d = mag2_s;
                prod_d = {WORD_ZERO, mag1_s};
            end else begin
                opnd_d = mag1_s;
                prod_d = {WORD_ZERO, mag2_s};
            end
        end else if (step_i) begin
            prod_d = step_s;
        end else begin
            prod_d = prod_q;
        end
    end

    // Sign-corrected result of the step in progress; sampled on the final step.
    always_comb begin
        if (is_div(op_q)) begin
            final_o = div_pick(op_q, step_s, neg_q);
        end else begin
            final_o = mul_pick(op_q, step_s, neg_q);
        end
    end

    // Datapath state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q <= {2*WORD_SIZE{1'b0}};
            opnd_q <= WORD_ZERO;
            op_q   <= 3'b000;
            neg_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// RV32M execute unit: claims M-extension instructions from the
// decode->execute register, holds them with stall until the result has
// been handed to writeback, and tags results with the ROB id.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies complete in a
// single cycle through a combinational multiplier; division is unchanged.
module exec_muldiv_unit
    import exec_muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    exec_muldiv_unit_if.slave bus
);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    word_t                result_q;
    logic [ROB_ID_SZ-1:0] rob_q;
    logic                 rv_q;

    logic  is_m_s;
    logic  div_zero_s;
    logic  ovf_s;
    logic  fast_s;
    word_t fast_res_s;
    word_t dp_final_s;
    logic  load_s;
    logic  step_s;

    // Decode: is this an M-extension instruction and does it need no iteration.
    always_comb begin
        is_m_s     = bus.valid && (bus.opcode == OPCODE_OP) && (bus.funct7 == FUNCT7_MEXT);
        div_zero_s = is_div(bus.funct3) && (bus.s2 == WORD_ZERO);
        ovf_s      = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM))
                   && (bus.s1 == WORD_MIN) && (bus.s2 == WORD_ONES);
    end

    // Results available without iterating: divide by zero, signed overflow
    // and, when enabled, the combinational multiplier.
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = WORD_ZERO;
        if (div_zero_s) begin
            fast_s     = 1'b1;
            fast_res_s = bus.funct3[1] ? bus.s1 : WORD_ONES;
        end else if (ovf_s) begin
            fast_s     = 1'b1;
            fast_res_s = bus.funct3[1] ? WORD_ZERO : WORD_MIN;
`ifdef MULDIV_FAST_MUL_EN
        end else if (!is_div(bus.funct3)) begin
            fast_s     = 1'b1;
            fast_res_s = mul_pick(bus.funct3,
                                  dword_t'(magnitude(bus.s1, s1_signed(bus.funct3)))
                                * dword_t'(magnitude(bus.s2, s2_signed(bus.funct3))),
                                  result_negative(bus.funct3, bus.s1, bus.s2));
`endif
        end else begin
            fast_s     = 1'b0;
            fast_res_s = WORD_ZERO;
        end
    end

    // Datapath control and the combinational hold request to decode.
    always_comb begin
        load_s    = (state_q == ST_IDLE) && is_m_s && !fast_s;
        step_s    = (state_q == ST_BUSY);
        bus.stall = reset && is_m_s && !((state_q == ST_DONE) && !bus.wb_stall);
    end

    muldiv_iter_datapath u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_s),
        .step_i   (step_s),
        .funct3_i (bus.funct3),
        .s1_i     (bus.s1),
        .s2_i     (bus.s2),
        .final_o  (dp_final_s)
    );

    // Control FSM with registered result, tag and valid outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            result_q <= WORD_ZERO;
            rob_q    <= {ROB_ID_SZ{1'b0}};
            rv_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_m_s) begin
                        rob_q <= bus.rob_id;
                        if (fast_s) begin
                            state_q  <= ST_DONE;
                            result_q <= fast_res_s;
                            rv_q     <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= CNT_W'(WORD_SIZE - 1);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_q  <= ST_DONE;
                        result_q <= dp_final_s;
                        rv_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (!bus.wb_stall) begin
                        state_q <= ST_IDLE;
                        rv_q    <= 1'b0;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rv_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.rob_id_out   = rob_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: a vector table applied
// back-to-back, a scoreboard popped at each writeback handoff, and
// hand-written sequences for writeback back-pressure, mid-op reset and
// non-M instructions.
module tb_exec_muldiv_unit;
    import exec_muldiv_unit_pkg::*;

    localparam int ITER_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [6:0]  rob;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [6:0]  rob;
        logic [31:0] res;
    } sb_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    sb_t  sb_q[$];
    vec_t vecs[18];

    exec_muldiv_unit_if bus_if ();

    exec_muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: a result is handed to writeback when valid and not back-pressured.
    always @(negedge clk) begin
        sb_t e;
        if (reset && bus_if.result_valid && !bus_if.wb_stall) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got result 0x%08h with no expected entry", bus_if.result);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", bus_if.result, e.res);
                check("sb_rob_id", {25'd0, bus_if.rob_id_out}, {25'd0, e.rob});
            end
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] rob);
        bus_if.valid  = 1'b1;
        bus_if.opcode = OPCODE_OP;
        bus_if.funct7 = FUNCT7_MEXT;
        bus_if.funct3 = f3;
        bus_if.s1     = a;
        bus_if.s2     = b;
        bus_if.rob_id = rob;
    endtask

    // Present an op (called just after a posedge), check stall and latency,
    // return just after the posedge on which the result was consumed.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] rob, input logic [31:0] exp_res, input int exp_lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        drive(f3, a, b, rob);
        sb_q.push_back('{rob: rob, res: exp_res});
        while (!seen && n < 100) begin
            @(negedge clk);
            if (bus_if.result_valid) begin
                seen = 1'b1;
                check($sformatf("latency_rob%0d", rob), n, exp_lat);
                check("stall_at_done", {31'd0, bus_if.stall}, 32'd0);
            end else begin
                if (n < exp_lat) begin
                    check("stall_busy", {31'd0, bus_if.stall}, 32'd1);
                end
                n++;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_rob%0d: got no result_valid in 100 cycles, want one at %0d", rob, exp_lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 7'd5,  32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 7'd6,  32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 7'd7,  32'h4000_0000, MUL_LAT};
        vecs[3]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         7'd8,  32'hFFFF_FFFD, ITER_LAT};
        vecs[4]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         7'd9,  32'hFFFF_FFFF, ITER_LAT};
        vecs[5]  = '{F3_DIVU,   32'd7,          32'd0,         7'd10, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 7'd11, 32'h0000_0000, 1};
        vecs[7]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 7'd12, 32'hFFFF_FFFF, MUL_LAT};
        vecs[8]  = '{F3_MULH,   32'hFFFF_FFFF,  32'd2,         7'd13, 32'hFFFF_FFFF, MUL_LAT};
        vecs[9]  = '{F3_DIVU,   32'd100,        32'd7,         7'd14, 32'd14,        ITER_LAT};
        vecs[10] = '{F3_REMU,   32'd100,        32'd7,         7'd15, 32'd2,         ITER_LAT};
        vecs[11] = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 7'd16, 32'd1,         ITER_LAT};
        vecs[12] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 7'd17, 32'h8000_0000, 1};
        vecs[13] = '{F3_REMU,   32'd5,          32'd0,         7'd18, 32'd5,         1};
        vecs[14] = '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 7'd19, 32'hFFFF_FFFD, ITER_LAT};
        vecs[15] = '{F3_MUL,    32'd3,          32'd4,         7'd20, 32'd12,        MUL_LAT};
        vecs[16] = '{F3_MULHU,  32'h8000_0000,  32'd4,         7'd21, 32'd2,         MUL_LAT};
        vecs[17] = '{F3_DIV,    32'hFFFF_FFF8,  32'hFFFF_FFFD, 7'd22, 32'd2,         ITER_LAT};

        // Reset with an M op presented: stall forced low, outputs cleared.
        reset = 1'b0;
        bus_if.wb_stall = 1'b0;
        drive(F3_MUL, 32'd3, 32'd4, 7'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, bus_if.stall}, 32'd0);
        check("rst_result_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("rst_result", bus_if.result, 32'd0);
        check("rst_rob_id_out", {25'd0, bus_if.rob_id_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus_if.valid = 1'b0;

        // Vector table, each op presented in the cycle after the previous handoff.
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rob, vecs[i].res, vecs[i].lat);
        end
        bus_if.valid = 1'b0;
        @(posedge clk);
        #1;

        // Writeback back-pressure: DONE held 4 cycles with stable outputs.
        bus_if.wb_stall = 1'b1;
        drive(F3_MUL, 32'd5, 32'd6, 7'd30);
        sb_q.push_back('{rob: 7'd30, res: 32'd30});
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (bus_if.result_valid) begin
                seen = 1'b1;
            end else begin
                n++;
            end
        end
        check("wbs_latency", n, MUL_LAT);
        for (int k = 0; k < 4; k++) begin
            check("wbs_result_valid", {31'd0, bus_if.result_valid}, 32'd1);
            check("wbs_result", bus_if.result, 32'd30);
            check("wbs_rob_id_out", {25'd0, bus_if.rob_id_out}, 32'd30);
            check("wbs_stall", {31'd0, bus_if.stall}, 32'd1);
            @(posedge clk);
            #1;
            if (k == 3) bus_if.wb_stall = 1'b0;
            @(negedge clk);
        end
        check("wbs_release_stall", {31'd0, bus_if.stall}, 32'd0);
        check("wbs_release_valid", {31'd0, bus_if.result_valid}, 32'd1);
        @(posedge clk);
        #1;
        run_op(F3_MUL, 32'd9, 32'd9, 7'd31, 32'd81, MUL_LAT);
        bus_if.valid = 1'b0;

        // Reset in cycle 10 of a DIVU discards it; re-presented op runs in full.
        drive(F3_DIVU, 32'd1000, 32'd10, 7'd40);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stall_low", {31'd0, bus_if.stall}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_result_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("midrst_stall", {31'd0, bus_if.stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_op(F3_DIVU, 32'd1000, 32'd10, 7'd40, 32'd100, ITER_LAT);
        bus_if.valid = 1'b0;

        // Non-M instructions: ADD (funct7=0) and OP-IMM with funct7=1 are ignored.
        drive(3'b000, 32'd1, 32'd2, 7'd50);
        bus_if.funct7 = 7'b0000000;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus_if.opcode = 7'b0010011;
            if (k == 2) bus_if.funct7 = FUNCT7_MEXT;
            @(negedge clk);
            check("nonm_stall", {31'd0, bus_if.stall}, 32'd0);
            check("nonm_result_valid", {31'd0, bus_if.result_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        run_op(F3_REMU, 32'd17, 32'd5, 7'd51, 32'd2, ITER_LAT);
        bus_if.valid = 1'b0;
        repeat (3) @(posedge clk);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
